// File: rtl/boctet_pkg.sv
// rtl/boctet_pkg.sv - shared kinds, beat counts, field widths and FSM states for the bOctet feeder
// BOCTET_FEEDER_CHECK_EN adds the DRAIN state used for protocol-error recovery.
package boctet_pkg;

   typedef enum logic [1:0] {
      KIND_WEIGHT  = 2'd0,
      KIND_ACT     = 2'd1,
      KIND_PSUM    = 2'd2,
      KIND_ILLEGAL = 2'd3
   } kind_e;

   localparam int BEATS_WEIGHT = 10;
   localparam int BEATS_ACT    = 4;
   localparam int BEATS_PSUM   = 2;
   localparam int W_CNT        = 4;

   localparam int W_BEAT  = 64;
   localparam int W_WDATA = 256;
   localparam int W_WSIGN = 64;
   localparam int W_WSEL0 = 64;
   localparam int W_WSEL1 = 128;
   localparam int W_SHIFT = 96;
   localparam int W_ACT   = 256;
   localparam int W_PSUM  = 128;
   localparam int W_WPACK = W_WDATA + W_WSIGN + W_WSEL0 + W_WSEL1 + W_SHIFT;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_ISSUE   = 2'd2
`ifdef BOCTET_FEEDER_CHECK_EN
      ,
      ST_DRAIN   = 2'd3
`endif
   } state_e;

   function automatic logic [W_CNT-1:0] beats_for(kind_e k);
      case (k)
         KIND_WEIGHT: beats_for = W_CNT'(BEATS_WEIGHT);
         KIND_ACT:    beats_for = W_CNT'(BEATS_ACT);
         default:     beats_for = W_CNT'(BEATS_PSUM);
      endcase
   endfunction

endpackage

// File: rtl/boctet_feeder_if.sv
// rtl/boctet_feeder_if.sv - 64-bit beat stream from the buffer read path into the feeder
interface boctet_feeder_if
   import boctet_pkg::*;
;
   logic [W_BEAT-1:0] in_data;
   logic [1:0]        in_kind;
   logic              in_last;
   logic              in_valid;
   logic              in_ready;

   modport master (output in_data, in_kind, in_last, in_valid, input in_ready);
   modport slave  (input in_data, in_kind, in_last, in_valid, output in_ready);
endinterface

// File: rtl/boctet_beat_ctr.sv
// rtl/boctet_beat_ctr.sv - beat counter: load to 1 on first beat, bump per handshake, flag final beat
module boctet_beat_ctr
   import boctet_pkg::*;
(
   input  logic             clk,
   input  logic             rstn,
   input  logic             load,
   input  logic             inc,
   input  logic [W_CNT-1:0] limit,
   output logic [W_CNT-1:0] cnt,
   output logic             term
);
   logic [W_CNT-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = W_CNT'(1);
      end else if (inc) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // cnt_q is the index of the beat currently on the bus
   assign cnt  = cnt_q;
   assign term = (cnt_q == limit - 1'b1);
endmodule

// File: rtl/boctet_feeder.sv
// rtl/boctet_feeder.sv - assembles typed beat packets into bOctet operand buses and pulses load strobes
// BOCTET_FEEDER_CHECK_EN enables in_last/kind checking, sticky err and the DRAIN state.
module boctet_feeder
   import boctet_pkg::*;
(
   input  logic                clk,
   input  logic                rstn,
   boctet_feeder_if.slave      in_if,
   output logic [W_WDATA-1:0]  weight_data_out,
   output logic [W_WSIGN-1:0]  weight_sign_out,
   output logic [W_WSEL0-1:0]  weight_sel_level0_out,
   output logic [W_WSEL1-1:0]  weight_sel_level1_out,
   output logic [W_SHIFT-1:0]  shift_offset_out,
   output logic [W_ACT-1:0]    activation_out,
   output logic [W_PSUM-1:0]   psum_out,
   output logic                weight_update,
   output logic                activation_update,
   output logic                psum_update,
   output logic                busy,
   output logic                err
);
   state_e             state_q, state_d;
   kind_e              kind_q, kind_d;
   kind_e              in_kind_e, wr_kind;
   logic               in_ready_q, in_ready_d;
   logic [W_WPACK-1:0] wgt_q, wgt_d;
   logic [W_ACT-1:0]   act_q, act_d;
   logic [W_PSUM-1:0]  psum_q, psum_d;
   logic [W_CNT-1:0]   beat_cnt, wr_idx;
   logic               hs, ctr_load, ctr_inc, ctr_term, wr_en;
`ifdef BOCTET_FEEDER_CHECK_EN
   logic               err_q, err_d;
`else
   logic               unused_last;
   assign unused_last = in_if.in_last;
`endif

   assign hs             = in_if.in_valid && in_ready_q;
   assign in_if.in_ready = in_ready_q;

   always_comb begin
      in_kind_e = kind_e'(in_if.in_kind);
`ifndef BOCTET_FEEDER_CHECK_EN
      if (in_kind_e == KIND_ILLEGAL) begin
         in_kind_e = KIND_PSUM;
      end
`endif
   end

   boctet_beat_ctr u_beat_ctr (
      .clk   (clk),
      .rstn  (rstn),
      .load  (ctr_load),
      .inc   (ctr_inc),
      .limit (beats_for(kind_q)),
      .cnt   (beat_cnt),
      .term  (ctr_term)
   );

   always_comb begin
      state_d  = state_q;
      kind_d   = kind_q;
      ctr_load = 1'b0;
      ctr_inc  = 1'b0;
      wr_en    = 1'b0;
      wr_idx   = beat_cnt;
      wr_kind  = kind_q;
`ifdef BOCTET_FEEDER_CHECK_EN
      err_d    = err_q;
`endif
      case (state_q)
         ST_IDLE: begin
            wr_idx  = '0;
            wr_kind = in_kind_e;
            if (hs) begin
               kind_d   = in_kind_e;
               ctr_load = 1'b1;
`ifdef BOCTET_FEEDER_CHECK_EN
               if (in_kind_e == KIND_ILLEGAL) begin
                  // an illegal single-beat packet has already ended, nothing left to drain
                  err_d   = 1'b1;
                  state_d = in_if.in_last ? ST_IDLE : ST_DRAIN;
               end else begin
                  wr_en = 1'b1;
                  if (in_if.in_last) begin
                     err_d = 1'b1;
                  end else begin
                     state_d = ST_COLLECT;
                  end
               end
`else
               wr_en   = 1'b1;
               state_d = ST_COLLECT;
`endif
            end
         end
         ST_COLLECT: begin
            if (hs) begin
               ctr_inc = 1'b1;
               wr_en   = 1'b1;
`ifdef BOCTET_FEEDER_CHECK_EN
               if (ctr_term) begin
                  if (in_if.in_last) begin
                     state_d = ST_ISSUE;
                  end else begin
                     err_d   = 1'b1;
                     state_d = ST_DRAIN;
                  end
               end else if (in_if.in_last) begin
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
               end
`else
               if (ctr_term) begin
                  state_d = ST_ISSUE;
               end
`endif
            end
         end
         ST_ISSUE: state_d = ST_IDLE;
`ifdef BOCTET_FEEDER_CHECK_EN
         ST_DRAIN: begin
            if (hs && in_if.in_last) begin
               state_d = ST_IDLE;
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase
      in_ready_d = (state_d != ST_ISSUE);
   end

   // beats land directly in the output registers; only the active kind is touched
   always_comb begin
      wgt_d  = wgt_q;
      act_d  = act_q;
      psum_d = psum_q;
      if (wr_en) begin
         case (wr_kind)
            KIND_WEIGHT: begin
               for (int k = 0; k < BEATS_WEIGHT - 1; k++) begin
                  if (wr_idx == W_CNT'(k)) wgt_d[W_BEAT*k +: W_BEAT] = in_if.in_data;
               end
               if (wr_idx == W_CNT'(BEATS_WEIGHT - 1)) begin
                  wgt_d[W_WPACK-1 -: W_BEAT/2] = in_if.in_data[W_BEAT/2-1:0];
               end
            end
            KIND_ACT: begin
               for (int k = 0; k < BEATS_ACT; k++) begin
                  if (wr_idx == W_CNT'(k)) act_d[W_BEAT*k +: W_BEAT] = in_if.in_data;
               end
            end
            KIND_PSUM: begin
               for (int k = 0; k < BEATS_PSUM; k++) begin
                  if (wr_idx == W_CNT'(k)) psum_d[W_BEAT*k +: W_BEAT] = in_if.in_data;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= ST_IDLE;
         kind_q     <= KIND_WEIGHT;
         in_ready_q <= 1'b0;
         wgt_q      <= '0;
         act_q      <= '0;
         psum_q     <= '0;
      end else begin
         state_q    <= state_d;
         kind_q     <= kind_d;
         in_ready_q <= in_ready_d;
         wgt_q      <= wgt_d;
         act_q      <= act_d;
         psum_q     <= psum_d;
      end
   end

`ifdef BOCTET_FEEDER_CHECK_EN
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   assign weight_data_out       = wgt_q[W_WDATA-1:0];
   assign weight_sign_out       = wgt_q[W_WDATA +: W_WSIGN];
   assign weight_sel_level0_out = wgt_q[W_WDATA+W_WSIGN +: W_WSEL0];
   assign weight_sel_level1_out = wgt_q[W_WDATA+W_WSIGN+W_WSEL0 +: W_WSEL1];
   assign shift_offset_out      = wgt_q[W_WPACK-1 -: W_SHIFT];
   assign activation_out        = act_q;
   assign psum_out              = psum_q;

   assign weight_update     = (state_q == ST_ISSUE) && (kind_q == KIND_WEIGHT);
   assign activation_update = (state_q == ST_ISSUE) && (kind_q == KIND_ACT);
   assign psum_update       = (state_q == ST_ISSUE) && (kind_q == KIND_PSUM);
   assign busy              = (state_q != ST_IDLE);
endmodule

// File: tb/tb_boctet_feeder.sv
// tb/tb_boctet_feeder.sv - randomized self-checking bench for boctet_feeder against a packet-level model
// Protocol-error scenarios run only when BOCTET_FEEDER_CHECK_EN is defined.
module tb_boctet_feeder;
   import boctet_pkg::*;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   boctet_feeder_if in_if ();

   logic [255:0] weight_data_out;
   logic [63:0]  weight_sign_out;
   logic [63:0]  weight_sel_level0_out;
   logic [127:0] weight_sel_level1_out;
   logic [95:0]  shift_offset_out;
   logic [255:0] activation_out;
   logic [127:0] psum_out;
   logic         weight_update, activation_update, psum_update, busy, err;

   boctet_feeder dut (
      .clk                   (clk),
      .rstn                  (rstn),
      .in_if                 (in_if),
      .weight_data_out       (weight_data_out),
      .weight_sign_out       (weight_sign_out),
      .weight_sel_level0_out (weight_sel_level0_out),
      .weight_sel_level1_out (weight_sel_level1_out),
      .shift_offset_out      (shift_offset_out),
      .activation_out        (activation_out),
      .psum_out              (psum_out),
      .weight_update         (weight_update),
      .activation_update     (activation_update),
      .psum_update           (psum_update),
      .busy                  (busy),
      .err                   (err)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int n_strobe = 0;
   int multi = 0;

   // model: the packet bits each bus should hold, LSB-first beat concatenation
   logic [639:0] exp_w = '0;
   logic [255:0] exp_a = '0;
   logic [127:0] exp_p = '0;

   wire [607:0] dut_w   = {shift_offset_out, weight_sel_level1_out, weight_sel_level0_out,
                           weight_sign_out, weight_data_out};
   wire [2:0]   dut_stb = {psum_update, activation_update, weight_update};

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (|dut_stb) n_strobe <= n_strobe + 1;
      if ($countones(dut_stb) > 1) multi <= multi + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d, required finish earlier", cyc);
      $fatal(1, "watchdog");
   end

   task automatic send_pkt(input int kind, input int nbeats, input int last_at, input int gap,
                           input bit fixed);
      int ek, lim, budget;
      logic [63:0] b;
      ek = kind;
`ifndef BOCTET_FEEDER_CHECK_EN
      if (ek == 3) ek = 2;
`endif
      lim = (ek == 0) ? 10 : (ek == 1) ? 4 : (ek == 2) ? 2 : 0;
      for (int i = 0; i < nbeats; i++) begin
         if (i > 0) repeat (gap) @(negedge clk);
         b = fixed ? {16{4'(i)}} : {$urandom, $urandom};
         in_if.in_data  = b;
         in_if.in_kind  = (i == 0) ? 2'(kind) : 2'($urandom);
         in_if.in_last  = (i == last_at);
         in_if.in_valid = 1'b1;
         budget = 0;
         while (in_if.in_ready !== 1'b1 && budget < 20) begin
            @(negedge clk);
            budget++;
         end
         if (in_if.in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout beat %0d in_ready=%b required 1", i, in_if.in_ready);
         end
         @(negedge clk);
         in_if.in_valid = 1'b0;
         in_if.in_last  = 1'b0;
         if (i < lim) begin
            case (ek)
               0: exp_w[64*i +: 64] = b;
               1: exp_a[64*i +: 64] = b;
               default: exp_p[64*i +: 64] = b;
            endcase
         end
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++; if (in_if.in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", in_if.in_ready); end
      checks++; if ({busy, err, dut_stb} !== 5'b0) begin errors++; $display("FAIL reset_ctrl got %b want 00000", {busy, err, dut_stb}); end
      checks++; if ({dut_w, activation_out, psum_out} !== '0) begin errors++; $display("FAIL reset_buses nonzero want all 0"); end
      rstn = 1'b1;
      @(negedge clk);
      checks++; if (in_if.in_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset got %b want 1", in_if.in_ready); end
   endtask

   task automatic test_weight();
      int n0;
      n0 = n_strobe;
      send_pkt(0, 10, 9, 0, 1'b1);
      checks++; if (dut_stb !== 3'b001) begin errors++; $display("FAIL weight_strobe got %b want 001", dut_stb); end
      checks++; if (dut_w !== exp_w[607:0]) begin errors++; $display("FAIL weight_bus got %h want %h", dut_w, exp_w[607:0]); end
      checks++; if (shift_offset_out !== 96'h99999999_8888888888888888) begin errors++; $display("FAIL weight_shift got %h want 999999998888888888888888", shift_offset_out); end
      checks++; if (weight_data_out !== 256'h3333333333333333_2222222222222222_1111111111111111_0000000000000000) begin
         errors++; $display("FAIL weight_data got %h want beats 3..0", weight_data_out); end
      @(negedge clk);
      checks++; if (dut_stb !== 3'b000) begin errors++; $display("FAIL weight_strobe_width got %b want 000", dut_stb); end
      checks++; if (n_strobe != n0 + 1) begin errors++; $display("FAIL weight_strobe_count got %0d want %0d", n_strobe, n0 + 1); end
      send_pkt(0, 10, 9, 1, 1'b0);
      checks++; if (dut_stb !== 3'b001) begin errors++; $display("FAIL weight_rand_strobe got %b want 001", dut_stb); end
      checks++; if (dut_w !== exp_w[607:0]) begin errors++; $display("FAIL weight_rand_bus got %h want %h", dut_w, exp_w[607:0]); end
      @(negedge clk);
   endtask

   task automatic test_act_gaps();
      send_pkt(1, 4, 3, 2, 1'b0);
      checks++; if (dut_stb !== 3'b010) begin errors++; $display("FAIL act_strobe got %b want 010", dut_stb); end
      checks++; if (activation_out !== exp_a) begin errors++; $display("FAIL act_bus got %h want %h", activation_out, exp_a); end
      checks++; if (in_if.in_ready !== 1'b0) begin errors++; $display("FAIL act_issue_ready got %b want 0", in_if.in_ready); end
      checks++; if (dut_w !== exp_w[607:0]) begin errors++; $display("FAIL act_weight_untouched got %h want %h", dut_w, exp_w[607:0]); end
      @(negedge clk);
      checks++; if ({in_if.in_ready, dut_stb} !== 4'b1000) begin errors++; $display("FAIL act_after_issue got %b want 1000", {in_if.in_ready, dut_stb}); end
   endtask

   task automatic test_psum();
      int last_at;
`ifdef BOCTET_FEEDER_CHECK_EN
      last_at = 1;
`else
      last_at = -1;
`endif
      send_pkt(2, 2, last_at, 1, 1'b0);
      checks++; if (dut_stb !== 3'b100) begin errors++; $display("FAIL psum_strobe got %b want 100", dut_stb); end
      checks++; if (psum_out !== exp_p) begin errors++; $display("FAIL psum_bus got %h want %h", psum_out, exp_p); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL psum_err got %b want 0", err); end
      @(negedge clk);
`ifndef BOCTET_FEEDER_CHECK_EN
      send_pkt(3, 2, -1, 0, 1'b0);
      checks++; if (dut_stb !== 3'b100) begin errors++; $display("FAIL kind3_as_psum_strobe got %b want 100", dut_stb); end
      checks++; if (psum_out !== exp_p) begin errors++; $display("FAIL kind3_as_psum_bus got %h want %h", psum_out, exp_p); end
      @(negedge clk);
`endif
   endtask

   task automatic test_back_to_back();
      int k, n, prev;
      logic [2:0] want;
      prev = 0;
      for (int p = 0; p < 8; p++) begin
         k = $urandom_range(0, 2);
         n = (k == 0) ? 10 : (k == 1) ? 4 : 2;
         want = 3'b001 << k;
         send_pkt(k, n, n - 1, 0, 1'b0);
         checks++; if (dut_stb !== want) begin errors++; $display("FAIL b2b_strobe pkt %0d got %b want %b", p, dut_stb, want); end
         checks++; if (in_if.in_ready !== 1'b0) begin errors++; $display("FAIL b2b_issue_ready pkt %0d got %b want 0", p, in_if.in_ready); end
         checks++; if ({activation_out, psum_out} !== {exp_a, exp_p}) begin errors++; $display("FAIL b2b_act_psum pkt %0d got %h_%h want %h_%h", p, activation_out, psum_out, exp_a, exp_p); end
         checks++; if (dut_w !== exp_w[607:0]) begin errors++; $display("FAIL b2b_weight pkt %0d got %h want %h", p, dut_w, exp_w[607:0]); end
         if (p > 0) begin
            checks++; if (cyc - prev != n + 1) begin errors++; $display("FAIL b2b_period pkt %0d got %0d want %0d", p, cyc - prev, n + 1); end
         end
         prev = cyc;
      end
      @(negedge clk);
      checks++; if (multi != 0) begin errors++; $display("FAIL strobe_exclusive got %0d overlaps want 0", multi); end
   endtask

`ifdef BOCTET_FEEDER_CHECK_EN
   task automatic test_protocol_errors();
      int n0;
      n0 = n_strobe;
      send_pkt(2, 1, 0, 0, 1'b0);
      repeat (3) @(negedge clk);
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL early_last_err got %b want 1", err); end
      checks++; if (n_strobe != n0) begin errors++; $display("FAIL early_last_nostrobe got %0d want %0d", n_strobe, n0); end
      checks++; if (psum_out !== exp_p) begin errors++; $display("FAIL early_last_psum got %h want %h", psum_out, exp_p); end
      send_pkt(2, 2, 1, 0, 1'b0);
      checks++; if (dut_stb !== 3'b100) begin errors++; $display("FAIL psum_after_err_strobe got %b want 100", dut_stb); end
      checks++; if (psum_out !== exp_p) begin errors++; $display("FAIL psum_after_err_bus got %h want %h", psum_out, exp_p); end
      @(negedge clk);
      n0 = n_strobe;
      send_pkt(3, 5, 4, 1, 1'b0);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL kind3_busy got %b want 0", busy); end
      send_pkt(0, 12, 11, 0, 1'b0);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL missing_last_busy got %b want 0", busy); end
      repeat (2) @(negedge clk);
      checks++; if (n_strobe != n0) begin errors++; $display("FAIL drain_nostrobe got %0d want %0d", n_strobe, n0); end
      checks++; if ({dut_w, activation_out, psum_out} !== {exp_w[607:0], exp_a, exp_p}) begin errors++; $display("FAIL drain_buses_changed"); end
   endtask
`endif

   task automatic test_mid_reset();
      int n0;
      n0 = n_strobe;
      send_pkt(0, 6, -1, 0, 1'b0);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy got %b want 1", busy); end
      rstn = 1'b0;
      #1;
      checks++; if ({in_if.in_ready, busy, err, dut_stb} !== 6'b0) begin errors++; $display("FAIL mid_reset_ctrl got %b want 000000", {in_if.in_ready, busy, err, dut_stb}); end
      checks++; if ({dut_w, activation_out, psum_out} !== '0) begin errors++; $display("FAIL mid_reset_buses nonzero want all 0"); end
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      checks++; if (n_strobe != n0) begin errors++; $display("FAIL mid_reset_nostrobe got %0d want %0d", n_strobe, n0); end
      exp_w = '0;
      exp_a = '0;
      exp_p = '0;
      send_pkt(1, 4, 3, 0, 1'b0);
      checks++; if (dut_stb !== 3'b010) begin errors++; $display("FAIL post_reset_act_strobe got %b want 010", dut_stb); end
      checks++; if (activation_out !== exp_a) begin errors++; $display("FAIL post_reset_act_bus got %h want %h", activation_out, exp_a); end
      checks++; if (dut_w !== exp_w[607:0]) begin errors++; $display("FAIL post_reset_weight got %h want 0", dut_w); end
      @(negedge clk);
   endtask

   initial begin
      in_if.in_data  = '0;
      in_if.in_kind  = '0;
      in_if.in_last  = 1'b0;
      in_if.in_valid = 1'b0;
      test_reset();
      test_weight();
      test_act_gaps();
      test_psum();
      test_back_to_back();
`ifdef BOCTET_FEEDER_CHECK_EN
      test_protocol_errors();
`endif
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
